ball_motion: RTL and testbench

Pong ball kinematics engine. It sits directly downstream of the frame-rate strobe generator and consumes its one-cycle `tick_i` pulse as the motion step. Each tick it advances the ball by a fixed speed, bounces the ball off the top/bottom walls and the two paddles, and detects misses. It drives registered ball coordinates to the renderer and one-cycle score pulses to the score keeper.

---
 rtl/ball_motion.sv | 183 ++++++++++++++++++
 tb/tb_ball_motion.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Pong ball kinematics: serve countdown, per-tick motion, wall/paddle bounces
// and miss detection, all stepped by the frame-rate strobe.
module ball_motion #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SPEED          = 2,
  parameter int SERVE_TICKS    = 60,
  parameter int X_W            = 10,
  parameter int Y_W            = 10
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           tick_i,
  input  logic           start_i,
  input  logic [Y_W-1:0] left_paddle_y_i,
  input  logic [Y_W-1:0] right_paddle_y_i,
  output logic [X_W-1:0] ball_x_o,
  output logic [Y_W-1:0] ball_y_o,
  output logic           dir_x_o,
  output logic           dir_y_o,
  output logic           active_o,
  output logic           score_left_o,
  output logic           score_right_o
);

  // One spare bit above the widest coordinate keeps every sum from wrapping.
  localparam int W     = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam int CNT_W = $clog2(SERVE_TICKS + 1);

  localparam logic [W-1:0] CX    = W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [W-1:0] CY    = W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [W-1:0] YMAX  = W'(SCREEN_H - BALL_SIZE);
  localparam logic [W-1:0] SW    = W'(SCREEN_W);
  localparam logic [W-1:0] BS    = W'(BALL_SIZE);
  localparam logic [W-1:0] PH    = W'(PADDLE_H);
  localparam logic [W-1:0] SPD   = W'(SPEED);
  localparam logic [W-1:0] FL    = W'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [W-1:0] FR    = W'(RIGHT_PADDLE_X);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;
  logic             dx_next, dy_next, active_next;
  logic             score_l_next, score_r_next;

  logic [W-1:0] bx, by, lp, rp, nx, ny;
  logic         ov_left, ov_right, miss;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      ball_x_o      <= X_W'(CX);
      ball_y_o      <= Y_W'(CY);
      dir_x_o       <= 1'b1;
      dir_y_o       <= 1'b1;
      active_o      <= 1'b0;
      score_left_o  <= 1'b0;
      score_right_o <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      ball_x_o      <= x_next;
      ball_y_o      <= y_next;
      dir_x_o       <= dx_next;
      dir_y_o       <= dy_next;
      active_o      <= active_next;
      score_left_o  <= score_l_next;
      score_right_o <= score_r_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    dx_next      = dir_x_o;
    dy_next      = dir_y_o;
    score_l_next = 1'b0;
    score_r_next = 1'b0;
    miss         = 1'b0;

    bx = W'(ball_x_o);
    by = W'(ball_y_o);
    lp = W'(left_paddle_y_i);
    rp = W'(right_paddle_y_i);
    nx = bx;
    ny = by;

    // Overlap uses the ball position before this tick's move.
    ov_left  = (by + BS > lp) && (by < lp + PH);
    ov_right = (by + BS > rp) && (by < rp + PH);

    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = SERVE;
          cnt_next   = SERVE_LOAD;
        end
      end

      SERVE: begin
        if (tick_i) begin
          if (cnt <= CNT_W'(1)) begin
            state_next = PLAY;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end

      PLAY: begin
        if (tick_i) begin
          if (dir_y_o) begin
            if (by + SPD >= YMAX) begin
              ny      = YMAX;
              dy_next = 1'b0;
            end else begin
              ny = by + SPD;
            end
          end else begin
            if (by <= SPD) begin
              ny      = '0;
              dy_next = 1'b1;
            end else begin
              ny = by - SPD;
            end
          end

          // Paddle hit is checked before the miss so a last-moment save wins.
          if (!dir_x_o) begin
            if (bx >= FL && bx <= FL + SPD && ov_left) begin
              nx      = FL;
              dx_next = 1'b1;
            end else if (bx <= SPD) begin
              miss         = 1'b1;
              score_r_next = 1'b1;
              dx_next      = 1'b0;
            end else begin
              nx = bx - SPD;
            end
          end else begin
            if (bx + BS <= FR && bx + BS + SPD >= FR && ov_right) begin
              nx      = FR - BS;
              dx_next = 1'b0;
            end else if (bx + BS + SPD >= SW) begin
              miss         = 1'b1;
              score_l_next = 1'b1;
              dx_next      = 1'b1;
            end else begin
              nx = bx + SPD;
            end
          end

          if (miss) begin
            nx         = CX;
            ny         = CY;
            state_next = SERVE;
            cnt_next   = SERVE_LOAD;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    x_next      = X_W'(nx);
    y_next      = Y_W'(ny);
    active_next = (state_next == PLAY);
  end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus queues hand-computed checkpoints,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic [9:0] left_py;
  logic [9:0] right_py;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x, dir_y, active, score_left, score_right;

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tag;
    string       name;
    logic [24:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ball_motion dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .tick_i           (tick),
    .start_i          (start),
    .left_paddle_y_i  (left_py),
    .right_paddle_y_i (right_py),
    .ball_x_o         (ball_x),
    .ball_y_o         (ball_y),
    .dir_x_o          (dir_x),
    .dir_y_o          (dir_y),
    .active_o         (active),
    .score_left_o     (score_left),
    .score_right_o    (score_right)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  function automatic logic [24:0] pack(input int x, input int y, input int dx, input int dy,
                                       input int act, input int sl, input int sr);
    return {10'(x), 10'(y), 1'(dx), 1'(dy), 1'(act), 1'(sl), 1'(sr)};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {ball_x, ball_y, dir_x, dir_y, active, score_left, score_right};
  endfunction

  function automatic string fmt(input logic [24:0] v);
    return $sformatf("x=%0d y=%0d dx=%0b dy=%0b act=%0b sl=%0b sr=%0b",
                     v[24:15], v[14:5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  task automatic check_output(input string name, input logic [24:0] got, input logic [24:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %s, want %s", name, fmt(got), fmt(want));
    end
  endtask

  // The monitor owns the comparison of queued expectations against the DUT.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cycle) begin
      mon_e = sb.pop_front();
      if (mon_e.tag < cycle) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: checkpoint skipped at cycle %0d, wanted cycle %0d",
                 mon_e.name, cycle, mon_e.tag);
      end else begin
        check_output(mon_e.name, dut_vec(), mon_e.vec);
      end
    end
  end

  task automatic push_expect(input string name, input int x, input int y, input int dx,
                             input int dy, input int act, input int sl, input int sr);
    exp_t e;
    e.tag  = cycle + 1;
    e.name = name;
    e.vec  = pack(x, y, dx, dy, act, sl, sr);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    tick = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int n);
    if (n > 0) begin
      tick = 1'b1;
      repeat (n) begin
        @(negedge clk);
        #1;
      end
      tick = 1'b0;
    end
  endtask

  task automatic expect_tick(input string name, input int x, input int y, input int dx,
                             input int dy, input int act, input int sl, input int sr);
    push_expect(name, x, y, dx, dy, act, sl, sr);
    apply_stimulus(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tick     = 1'b0;
    start    = 1'b0;
    left_py  = 10'd400;
    right_py = 10'd0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    push_expect("reset_state", 316, 236, 1, 1, 0, 0, 0);
    idle(1);

    start = 1'b1;
    idle(1);
    start = 1'b0;

    // First serve: ball parked at centre until the 60th tick
    expect_tick("serve_t1", 316, 236, 1, 1, 0, 0, 0);
    apply_stimulus(57);
    expect_tick("serve_t59", 316, 236, 1, 1, 0, 0, 0);
    expect_tick("serve_t60", 316, 236, 1, 1, 1, 0, 0);

    expect_tick("play_t1", 318, 238, 1, 1, 1, 0, 0);
    apply_stimulus(115);
    expect_tick("play_t117", 550, 470, 1, 1, 1, 0, 0);
    expect_tick("bottom_wall", 552, 472, 1, 0, 1, 0, 0);
    expect_tick("play_t119", 554, 470, 1, 0, 1, 0, 0);

    // Right paddle moves into the path; start_i during PLAY must be ignored
    right_py = 10'd400;
    start    = 1'b1;
    apply_stimulus(25);
    start    = 1'b0;
    expect_tick("play_t145", 606, 418, 1, 0, 1, 0, 0);
    expect_tick("right_hit", 608, 416, 0, 0, 1, 0, 0);

    apply_stimulus(207);
    expect_tick("top_wall", 192, 0, 0, 1, 1, 0, 0);
    apply_stimulus(83);
    expect_tick("left_no_overlap", 24, 168, 0, 1, 1, 0, 0);
    apply_stimulus(10);
    expect_tick("before_left_miss", 2, 190, 0, 1, 1, 0, 0);
    expect_tick("left_miss", 316, 236, 0, 1, 0, 0, 1);
    expect_tick("score_r_one_cycle", 316, 236, 0, 1, 0, 0, 0);
    apply_stimulus(58);
    expect_tick("reserve_right", 316, 236, 0, 1, 1, 0, 0);

    // Ball now heads left-down toward the left paddle at y=400
    apply_stimulus(116);
    expect_tick("b_t117", 82, 470, 0, 1, 1, 0, 0);
    expect_tick("b_bottom_wall", 80, 472, 0, 0, 1, 0, 0);
    apply_stimulus(26);
    expect_tick("b_t145", 26, 418, 0, 0, 1, 0, 0);
    expect_tick("left_hit", 24, 416, 1, 0, 1, 0, 0);

    right_py = 10'd0;
    apply_stimulus(207);
    expect_tick("c_top_wall", 440, 0, 1, 1, 1, 0, 0);
    apply_stimulus(94);
    expect_tick("before_right_miss", 630, 190, 1, 1, 1, 0, 0);
    expect_tick("right_miss", 316, 236, 1, 1, 0, 1, 0);
    expect_tick("score_l_one_cycle", 316, 236, 1, 1, 0, 0, 0);
    apply_stimulus(58);
    expect_tick("reserve_left", 316, 236, 1, 1, 1, 0, 0);
    expect_tick("resume_t1", 318, 238, 1, 1, 1, 0, 0);
    apply_stimulus(3);

    // Asynchronous reset between clock edges must act without a clock
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_output("async_reset", dut_vec(), pack(316, 236, 1, 1, 0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    expect_tick("idle_ignores_tick", 316, 236, 1, 1, 0, 0, 0);
    apply_stimulus(2);
    expect_tick("idle_still", 316, 236, 1, 1, 0, 0, 0);

    idle(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
